// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Shares a single UART transmitter between NUM_REQ byte requesters using a
// round-robin arbiter. A granted byte is latched into tx_data. The
// transmitter gets a one-cycle tx_load pulse. The block then waits out the
// frame (FRAME_CYCLES) and an optional inter-frame gap (GAP_CYCLES) before
// granting again. The issue period from one transfer to the next possible
// transfer is 1 (IDLE) + 1 (LOAD) + FRAME_CYCLES + GAP_CYCLES cycles.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   en         1 = grants allowed in IDLE; an in-flight frame always completes
//   req_valid  per-requester "holding a byte" flags
//   req_data   byte of requester i at [i*N +: N]
//   req_ready  one-hot (or zero) accept strobe, combinational, IDLE only
//   tx_data    byte presented to the transmitter
//   tx_load    one-cycle load pulse to the transmitter
//   busy       frame in progress (state != IDLE)
//   grant_id   requester owning the current or last frame
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; grants combinationally when en=1
// LOAD  | tx_load pulse, byte handed to the transmitter
// SEND  | transmitter shifting the frame, FRAME_CYCLES cycles
// GAP   | idle line between frames, GAP_CYCLES cycles (skipped if 0)
module uart_tx_scheduler #(
    parameter int N            = 8,
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = N + 3,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*N-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [N-1:0]               tx_data,
    output logic                       tx_load,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int IDW     = $clog2(NUM_REQ);
    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CW      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]     state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] winner;
    logic           found;
    logic           xfer;
    int             idx;

    // Scan offsets from high to low so the smallest offset from rr_ptr
    // (the first set bit going upward with wrap) is the last one written.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[idx[IDW-1:0]]) begin
                winner = idx[IDW-1:0];
                found  = 1'b1;
            end
        end
    end

    // rst is included so req_ready is low while reset is held, even before
    // any clock edge.
    assign xfer = (state == S_IDLE) && en && found && !rst;

    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[winner] = 1'b1;
    end

    assign tx_load = (state == S_LOAD);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            cnt      <= '0;
            tx_data  <= '0;
            grant_id <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        tx_data  <= req_data[winner*N +: N];
                        grant_id <= winner;
                        rr_ptr   <= (winner == IDW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt   <= '0;
                    state <= S_SEND;
                end
                S_SEND: begin
                    if (cnt == CW'(FRAME_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt == CW'(GAP_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
